snake_body_tracker: RTL

Parametrised successor to the single-head snake mover. It tracks the full snake (head plus body) in a circular position buffer and a per-cell occupancy bitmap, and enforces a no-180-degree turn rule. It detects wall and self collisions, including the legal tail-chase case, and supports wall or wrap-around modes. It sits between the game-clock move pulse and the item generator and renderer, and provides a registered occupancy query port.

---
 rtl/snake_body_tracker_pkg.sv | 28 ++
 rtl/snake_body_tracker_if.sv | 34 +++
 rtl/snake_body_tracker_pos_ring.sv | 59 +++++
 rtl/snake_body_tracker.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/snake_body_tracker_pkg.sv
// Shared types and helpers for the snake body tracker: direction codes,
// packed grid cell and the reverse-direction test.
package snake_body_tracker_pkg;

    localparam int CELL_W = 8;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef struct packed {
        logic [CELL_W-1:0] x;
        logic [CELL_W-1:0] y;
    } cell_t;

    // Opposite directions share the axis bit and differ in the sign bit.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic int cell_index(input int x, input int y, input int w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// Control and status bundle between the game logic and the snake body tracker.
interface snake_body_tracker_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    logic          i_step;
    logic          i_pause;
    logic [1:0]    i_dir_req;
    logic          i_dir_valid;
    logic          i_grow;
    logic [XW-1:0] i_qx;
    logic [YW-1:0] i_qy;
    logic [XW-1:0] o_head_x;
    logic [YW-1:0] o_head_y;
    logic [XW-1:0] o_tail_x;
    logic [YW-1:0] o_tail_y;
    logic [1:0]    o_dir;
    logic [7:0]    o_length;
    logic          o_full;
    logic          o_dead;
    logic          o_q_occ;

    modport master (
        output i_step, i_pause, i_dir_req, i_dir_valid, i_grow, i_qx, i_qy,
        input  o_head_x, o_head_y, o_tail_x, o_tail_y, o_dir, o_length,
               o_full, o_dead, o_q_occ
    );

    modport slave (
        input  i_step, i_pause, i_dir_req, i_dir_valid, i_grow, i_qx, i_qy,
        output o_head_x, o_head_y, o_tail_x, o_tail_y, o_dir, o_length,
               o_full, o_dead, o_q_occ
    );
endinterface

// File: rtl/snake_body_tracker_pos_ring.sv
// Circular buffer of snake cells: head pointer advances on push, tail pointer
// advances on pop, both wrapping modulo DEPTH.
module snake_pos_ring
    import snake_body_tracker_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int INIT_LEN = 2,
    parameter int INIT_X   = 8,
    parameter int INIT_Y   = 4
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_push,
    input  logic  i_pop,
    input  cell_t i_cell,
    output cell_t o_head,
    output cell_t o_tail
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cell_t         r_buf [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] w_head_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_head_nxt = ptr_inc(r_head);

    // Slot 0 holds the initial tail, slot INIT_LEN the initial head.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i <= INIT_LEN) begin
                    r_buf[i].x <= CELL_W'(INIT_X);
                    r_buf[i].y <= CELL_W'(INIT_Y - INIT_LEN + i);
                end else begin
                    r_buf[i] <= '0;
                end
            end
            r_head <= PW'(INIT_LEN);
            r_tail <= '0;
        end else begin
            if (i_push) begin
                r_buf[w_head_nxt] <= i_cell;
                r_head            <= w_head_nxt;
            end
            if (i_pop) begin
                r_tail <= ptr_inc(r_tail);
            end
        end
    end

    assign o_head = r_buf[r_head];
    assign o_tail = r_buf[r_tail];

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body tracker: moves the head on each step, keeps an occupancy bitmap,
// detects wall/self collisions and serves a registered occupancy query.
module snake_body_tracker
    import snake_body_tracker_pkg::*;
#(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int MAX_LEN  = 63,
    parameter int INIT_LEN = 2,
    parameter int WRAP     = 0
) (
    input logic           i_clk,
    input logic           i_rst,
    snake_body_tracker_if.slave bus
);
    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = $clog2(NCELL);
    localparam int HX0   = GRID_W / 2;
    localparam int HY0   = GRID_H / 4;

    // state    | meaning
    // ST_ALIVE | steps move the snake
    // ST_DEAD  | collision seen, steps ignored until reset
    typedef enum logic {ST_ALIVE = 1'b0, ST_DEAD = 1'b1} state_e;

    state_e         r_state, w_state_nxt;
    dir_e           r_dir, r_pend;
    logic [7:0]     r_len;
    logic [NCELL-1:0] r_occ;
    logic           r_qocc;
    cell_t          w_head, w_tail, w_next;
    logic           w_edge, w_wall, w_self, w_alive, w_move, w_die, w_commit;
    logic           w_full, w_grow, w_pop, w_q_in;
    logic [IW-1:0]  w_next_idx, w_tail_idx, w_q_idx;
    logic [XW:0]    w_qx_ext;
    logic [YW:0]    w_qy_ext;

    snake_pos_ring #(
        .DEPTH    (MAX_LEN + 1),
        .INIT_LEN (INIT_LEN),
        .INIT_X   (HX0),
        .INIT_Y   (HY0)
    ) u_ring (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (w_commit),
        .i_pop  (w_pop),
        .i_cell (w_next),
        .o_head (w_head),
        .o_tail (w_tail)
    );

    // Edge crossings always produce the wrapped cell; w_wall decides if it kills.
    always_comb begin
        w_next = w_head;
        w_edge = 1'b0;
        case (r_pend)
            DIR_UP:
                if (w_head.y == CELL_W'(GRID_H - 1)) begin w_edge = 1'b1; w_next.y = '0; end
                else w_next.y = w_head.y + CELL_W'(1);
            DIR_DOWN:
                if (w_head.y == '0) begin w_edge = 1'b1; w_next.y = CELL_W'(GRID_H - 1); end
                else w_next.y = w_head.y - CELL_W'(1);
            DIR_LEFT:
                if (w_head.x == '0) begin w_edge = 1'b1; w_next.x = CELL_W'(GRID_W - 1); end
                else w_next.x = w_head.x - CELL_W'(1);
            DIR_RIGHT:
                if (w_head.x == CELL_W'(GRID_W - 1)) begin w_edge = 1'b1; w_next.x = '0; end
                else w_next.x = w_head.x + CELL_W'(1);
        endcase
    end

    assign w_next_idx = IW'(cell_index(int'(w_next.x), int'(w_next.y), GRID_W));
    assign w_tail_idx = IW'(cell_index(int'(w_tail.x), int'(w_tail.y), GRID_W));
    assign w_full     = (r_len == 8'(MAX_LEN));
    assign w_grow     = bus.i_grow && !w_full;
    assign w_wall     = w_edge && (WRAP == 0);
    // Stepping onto the tail is legal only when the tail moves away this step.
    assign w_self     = r_occ[w_next_idx] && !((w_next == w_tail) && !w_grow);
    assign w_move     = bus.i_step && !bus.i_pause && w_alive;
    assign w_die      = w_move && (w_wall || w_self);
    assign w_commit   = w_move && !w_die;
    assign w_pop      = w_commit && !w_grow;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_ALIVE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ALIVE: if (w_die) w_state_nxt = ST_DEAD;
            ST_DEAD:  w_state_nxt = ST_DEAD;
        endcase
    end

    always_comb begin
        w_alive = (r_state == ST_ALIVE);
    end

    assign w_qx_ext = {1'b0, bus.i_qx};
    assign w_qy_ext = {1'b0, bus.i_qy};
    assign w_q_in   = (w_qx_ext < (XW+1)'(GRID_W)) && (w_qy_ext < (YW+1)'(GRID_H));
    assign w_q_idx  = IW'(cell_index(int'(bus.i_qx), int'(bus.i_qy), GRID_W));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dir  <= DIR_UP;
            r_pend <= DIR_UP;
            r_len  <= 8'(INIT_LEN);
            r_qocc <= 1'b0;
            r_occ  <= '0;
            for (int k = 0; k <= INIT_LEN; k++) begin
                r_occ[IW'(cell_index(HX0, HY0 - k, GRID_W))] <= 1'b1;
            end
        end else begin
            if (bus.i_dir_valid && !is_reverse(bus.i_dir_req, r_dir)) begin
                r_pend <= dir_e'(bus.i_dir_req);
            end
            if (w_commit) begin
                r_dir <= r_pend;
                if (w_grow) r_len <= r_len + 8'd1;
                if (w_pop)  r_occ[w_tail_idx] <= 1'b0;
                r_occ[w_next_idx] <= 1'b1;
            end
            r_qocc <= w_q_in ? r_occ[w_q_idx] : 1'b0;
        end
    end

    assign bus.o_head_x = w_head.x[XW-1:0];
    assign bus.o_head_y = w_head.y[YW-1:0];
    assign bus.o_tail_x = w_tail.x[XW-1:0];
    assign bus.o_tail_y = w_tail.y[YW-1:0];
    assign bus.o_dir    = r_dir;
    assign bus.o_length = r_len;
    assign bus.o_full   = w_full;
    assign bus.o_dead   = !w_alive;
    assign bus.o_q_occ  = r_qocc;

endmodule
